pulse_store: RTL

Write-side companion to the pulse instruction memory. It accepts decoded pulse commands (address plus frequency, phase, amplitude, start time and length) over a valid/ready stream. Each command is packed into the 256-bit pulse instruction layout and issued on the memory write port, arbitrated by a grant from the fetch side. It also provides a bulk-clear sequence that zeroes every memory entry.

---
 rtl/pulse_store.sv | 212 +++++++++++++++++++++
 1 files changed

// File: rtl/pulse_store.sv
// pulse_store
// Write-side companion to the pulse instruction memory. Decoded pulse commands
// arrive on a valid/ready stream, are packed into the 256-bit pulse instruction
// layout, buffered in a small FIFO and issued on a registered memory write port
// that completes a write on mem_we && mem_wr_ready. A clear request drains any
// buffered commands and then sweeps zeros over every memory entry.
//
// Ports:
//   clk, rst                      - clock, synchronous active-high reset
//   in_valid/in_ready             - command stream handshake
//   in_addr, in_frequency, in_phase, in_amplitude, in_t_start, in_t_len
//                                 - command fields
//   clear_req                     - one-cycle request to zero all entries
//   mem_wr_ready                  - write-port grant from the fetch side
//   mem_we, mem_waddr, mem_wdata  - registered write port
//   busy                          - any buffered, pending or in-progress work
//   range_err, err_clr            - sticky t_start overflow flag and its clear
//   wr_count                      - saturating count of completed command writes
module pulse_store #(
    parameter int DEPTH      = 32,
    parameter int ADDR_W     = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [31:0]       in_frequency,
    input  logic [15:0]       in_phase,
    input  logic [13:0]       in_amplitude,
    input  logic [27:0]       in_t_start,
    input  logic [19:0]       in_t_len,
    input  logic              clear_req,
    input  logic              mem_wr_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_waddr,
    output logic [255:0]      mem_wdata,
    output logic              busy,
    output logic              range_err,
    input  logic              err_clr,
    output logic [15:0]       wr_count
);

    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = PTR_W + 1;
    // Meaningful payload bits of the 256-bit word; everything above is zero.
    localparam int PAY_W  = 108;
    localparam int WORD_W = ADDR_W + PAY_W;
    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(FIFO_DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

    state_t              state_reg;
    logic [PTR_W-1:0]    wr_ptr_reg;
    logic [PTR_W-1:0]    rd_ptr_reg;
    logic [CNT_W-1:0]    fifo_count_reg;
    logic [WORD_W-1:0]   fifo_mem [FIFO_DEPTH];

    logic                mem_we_reg;
    logic [ADDR_W-1:0]   mem_waddr_reg;
    logic [255:0]        mem_wdata_reg;
    logic                range_err_reg;
    logic [15:0]         wr_count_reg;

    logic                fifo_full;
    logic                fifo_empty;
    logic                push;
    logic                pop;
    logic                out_free;
    logic                drained;
    logic                start_clear;
    logic                t_start_ovf;
    logic [25:0]         t_start_sat;
    logic [WORD_W-1:0]   push_word;
    logic [WORD_W-1:0]   head_word;

    assign fifo_full  = (fifo_count_reg == FULL_CNT);
    assign fifo_empty = (fifo_count_reg == '0);

    assign in_ready = !fifo_full && (state_reg == IDLE);
    assign push     = in_valid && in_ready;

    // The output register can take a new word when it is empty or its
    // current write is being granted this cycle.
    assign out_free = !mem_we_reg || mem_wr_ready;
    assign pop      = !fifo_empty && out_free && (state_reg != CLEAR);

    // Nothing buffered and nothing on the write port. A command accepted in
    // the same cycle as clear_req must still be written before the sweep.
    assign drained     = fifo_empty && !mem_we_reg;
    assign start_clear = ((state_reg == IDLE) && clear_req && drained && !push) ||
                         ((state_reg == DRAIN) && drained);

    assign t_start_ovf = |in_t_start[27:26];
    assign t_start_sat = t_start_ovf ? 26'h3FFFFFF : in_t_start[25:0];
    assign push_word   = {in_addr, in_t_len, t_start_sat, in_amplitude,
                          in_phase, in_frequency};
    assign head_word   = fifo_mem[rd_ptr_reg];

    // Command buffer storage: one register bank per entry, no reset needed
    // since the occupancy count qualifies every read.
    generate
        for (genvar gi = 0; gi < FIFO_DEPTH; gi++) begin : g_fifo_entry
            localparam logic [PTR_W-1:0] ENTRY_IDX = PTR_W'(gi);
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == ENTRY_IDX)) begin
                    fifo_mem[gi] <= push_word;
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            fifo_count_reg <= '0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({push, pop})
                2'b10:   fifo_count_reg <= fifo_count_reg + 1'b1;
                2'b01:   fifo_count_reg <= fifo_count_reg - 1'b1;
                default: fifo_count_reg <= fifo_count_reg;
            endcase
        end
    end

    // Sticky overflow flag; a new overflow wins over a simultaneous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            range_err_reg <= 1'b0;
        end else if (push && t_start_ovf) begin
            range_err_reg <= 1'b1;
        end else if (err_clr) begin
            range_err_reg <= 1'b0;
        end
    end

    // Control FSM together with the registered write port and write counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            mem_we_reg    <= 1'b0;
            mem_waddr_reg <= '0;
            mem_wdata_reg <= '0;
            wr_count_reg  <= '0;
        end else begin
            // Only command writes are counted; sweeps enter CLEAR with the
            // port idle, so no command write can be granted while in CLEAR.
            if (mem_we_reg && mem_wr_ready && (state_reg != CLEAR) &&
                (wr_count_reg != 16'hFFFF)) begin
                wr_count_reg <= wr_count_reg + 16'd1;
            end

            case (state_reg)
                CLEAR: begin
                    if (mem_wr_ready) begin
                        if (mem_waddr_reg == LAST_ADDR) begin
                            mem_we_reg   <= 1'b0;
                            state_reg    <= IDLE;
                            wr_count_reg <= '0;
                        end else begin
                            mem_waddr_reg <= mem_waddr_reg + 1'b1;
                        end
                    end
                end
                default: begin
                    if (start_clear) begin
                        // First zero write goes out straight away at entry 0.
                        state_reg     <= CLEAR;
                        mem_we_reg    <= 1'b1;
                        mem_waddr_reg <= '0;
                        mem_wdata_reg <= '0;
                    end else begin
                        if ((state_reg == IDLE) && clear_req) begin
                            state_reg <= DRAIN;
                        end
                        if (out_free) begin
                            if (!fifo_empty) begin
                                mem_we_reg    <= 1'b1;
                                mem_waddr_reg <= head_word[WORD_W-1:PAY_W];
                                mem_wdata_reg <= {{(256-PAY_W){1'b0}},
                                                  head_word[PAY_W-1:0]};
                            end else begin
                                mem_we_reg <= 1'b0;
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign mem_we    = mem_we_reg;
    assign mem_waddr = mem_waddr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign range_err = range_err_reg;
    assign wr_count  = wr_count_reg;
    assign busy      = !fifo_empty || mem_we_reg || (state_reg != IDLE);

endmodule
